// File: rtl/timer_pkg.sv
// Shared definitions for the phase timer and its neighbours: FSM state
// encoding, default counter width and the named phase lengths used by the
// preset generator.
package timer_pkg;

    // Timer FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default counter / preset width
    localparam int TIMER_W = 6;

    // Phase lengths in time units
    localparam logic [TIMER_W-1:0] PHASE_LONG  = 6'd30;
    localparam logic [TIMER_W-1:0] PHASE_MID   = 6'd15;
    localparam logic [TIMER_W-1:0] PHASE_ALT   = 6'd22;
    localparam logic [TIMER_W-1:0] PHASE_SHORT = 6'd5;

endpackage

// File: rtl/bin2bcd.sv
// Combinational binary to two-digit BCD converter (shift-and-add-3).
// Correct for inputs 0..99; the timer only presents 0..63.
module bin2bcd #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] bin,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    logic [7:0] bcd;

    // Double-dabble: adjust each digit >= 5 before every shift of a new bit in
    always_comb begin
        bcd = 8'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            bcd = {bcd[6:0], bin[i]};
        end
    end

    assign tens = bcd[7:4];
    assign ones = bcd[3:0];

endmodule

// File: rtl/preset_timer.sv
// Loadable down-counting phase timer. A load starts an interval of
// `preset` ticks; a one-cycle `done` marks its end (or an immediate zero
// preset). Define PRESET_TIMER_BCD_EN to add the bcd_tens/bcd_ones view of
// the remaining count for the seven-segment path.
module preset_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] preset,
    input  logic             tick,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             busy,
`ifdef PRESET_TIMER_BCD_EN
    output logic             done,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
`else
    output logic             done
`endif
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q,  done_d;

    // Next-state logic: load has priority over everything, then accepted ticks
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            // A zero preset ends immediately; an aborted interval never pulses done
            if (preset != '0) begin
                count_d = preset;
                state_d = RUN;
            end else begin
                count_d = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end else if (state_q == RUN && tick && !hold) begin
            // Held ticks are dropped; count never goes below zero
            if (count_q != '0) begin
                count_d = count_q - CNT_ONE;
            end
            if (count_q == CNT_ONE || count_q == '0) begin
                done_d  = (count_q == CNT_ONE);
                state_d = IDLE;
            end
        end
    end

    // State, count and done registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

`ifdef PRESET_TIMER_BCD_EN
    bin2bcd #(
        .WIDTH (WIDTH)
    ) u_bin2bcd (
        .bin  (count_q),
        .tens (bcd_tens),
        .ones (bcd_ones)
    );
`endif

endmodule

// File: tb/tb_preset_timer.sv
// Directed bench for preset_timer: a cycle-by-cycle vector table followed by
// hand-written multi-cycle sequences (spaced ticks, hold, reload, reset).
module tb_preset_timer;
    import timer_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [5:0] preset;
    logic       tick;
    logic       hold;
    logic [5:0] count;
    logic       busy;
    logic       done;
`ifdef PRESET_TIMER_BCD_EN
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
`endif

    int checks;
    int errors;

    preset_timer #(.WIDTH(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .preset   (preset),
        .tick     (tick),
        .hold     (hold),
        .count    (count),
        .busy     (busy),
`ifdef PRESET_TIMER_BCD_EN
        .done     (done),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones)
`else
        .done     (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [5:0] pre;
        logic       tk;
        logic       hd;
        logic [5:0] exp_count;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Load a value (optionally with a tick); returns at the following negedge
    task automatic do_load(input logic [5:0] v, input logic t);
        @(negedge clk);
        load = 1'b1; preset = v; tick = t;
        @(negedge clk);
        load = 1'b0; tick = 1'b0;
    endtask

    // Issue n ticks, `gap` cycles apart, holding ticks with index in [hf,ht)
    task automatic do_ticks(input int n, input int gap, input int hf, input int ht,
                            output int dones);
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            hold = (i >= hf && i < ht);
            @(negedge clk);
            tick = 1'b0;
            hold = 1'b0;
            if (done) dones++;
            for (int g = 1; g < gap; g++) begin
                @(negedge clk);
                if (done) dones++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        logic [5:0] bvals [4];
        checks = 0;
        errors = 0;
        rst_n = 1'b0; load = 1'b0; preset = 6'd0; tick = 1'b0; hold = 1'b0;

        // ld, preset, tick, hold -> count, busy, done (after the edge)
        vecs[0]  = '{1'b1, 6'd5,  1'b0, 1'b0, 6'd5,  1'b1, 1'b0};
        vecs[1]  = '{1'b0, 6'd0,  1'b0, 1'b0, 6'd5,  1'b1, 1'b0};
        vecs[2]  = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd4,  1'b1, 1'b0};
        vecs[3]  = '{1'b0, 6'd0,  1'b1, 1'b1, 6'd4,  1'b1, 1'b0};
        vecs[4]  = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd3,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd2,  1'b1, 1'b0};
        vecs[6]  = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd1,  1'b1, 1'b0};
        vecs[7]  = '{1'b0, 6'd0,  1'b0, 1'b0, 6'd1,  1'b1, 1'b0};
        vecs[8]  = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 1'b1};
        vecs[9]  = '{1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 1'b0};
        vecs[11] = '{1'b1, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 1'b1};
        vecs[12] = '{1'b1, 6'd30, 1'b0, 1'b0, 6'd30, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd29, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 1'b1};
        vecs[15] = '{1'b1, 6'd30, 1'b0, 1'b0, 6'd30, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 6'd2,  1'b1, 1'b0, 6'd2,  1'b1, 1'b0};
        vecs[17] = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd1,  1'b1, 1'b0};
        vecs[18] = '{1'b1, 6'd22, 1'b1, 1'b0, 6'd22, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 6'd0,  1'b0, 1'b1, 6'd22, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 6'd1,  1'b0, 1'b0, 6'd1,  1'b1, 1'b0};
        vecs[21] = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 1'b1};
        vecs[22] = '{1'b1, 6'd15, 1'b1, 1'b0, 6'd15, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 6'd0,  1'b0, 1'b0, 6'd15, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
`ifdef PRESET_TIMER_BCD_EN
        chk("reset_tens", int'(bcd_tens), 0);
        chk("reset_ones", int'(bcd_ones), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table, one vector per consecutive clock cycle
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            load = vecs[i].ld; preset = vecs[i].pre; tick = vecs[i].tk; hold = vecs[i].hd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].exp_count));
            chk($sformatf("vec%0d_busy", i),  int'(busy),  int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_done", i),  int'(done),  int'(vecs[i].exp_done));
        end
        @(negedge clk);
        load = 1'b0; tick = 1'b0; hold = 1'b0;
        do_load(6'd1, 1'b0);
        do_ticks(1, 1, 0, 0, d);

        // Basic count: preset 5, ticks one per 4 cycles
        do_load(PHASE_SHORT, 1'b0);
        chk("basic_load", int'(count), 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            chk($sformatf("basic_cnt%0d", i), int'(count), 4 - i);
            chk($sformatf("basic_done%0d", i), int'(done), (i == 4) ? 1 : 0);
            chk($sformatf("basic_busy%0d", i), int'(busy), (i == 4) ? 0 : 1);
            repeat (2) @(negedge clk);
        end
        chk("basic_done_single", int'(done), 0);

        // Hold: 15 accepted ticks out of 18 issued
        do_load(PHASE_MID, 1'b0);
        do_ticks(17, 2, 5, 8, d);
        chk("hold_count_17", int'(count), 1);
        chk("hold_dones_17", d, 0);
        do_ticks(1, 2, 0, 0, d);
        chk("hold_count_18", int'(count), 0);
        chk("hold_dones_18", d, 1);

        // Reload with simultaneous tick while running
        do_load(PHASE_LONG, 1'b0);
        do_ticks(23, 1, 0, 0, d);
        chk("reload_count7", int'(count), 7);
        chk("reload_dones_pre", d, 0);
        do_load(PHASE_ALT, 1'b1);
        chk("reload_count22", int'(count), 22);
        chk("reload_no_done", int'(done), 0);
        do_ticks(22, 1, 0, 0, d);
        chk("reload_final_count", int'(count), 0);
        chk("reload_dones", d, 1);

        // Zero preset then back-to-back load while done is high
        do_load(6'd0, 1'b0);
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 0);
        do_load(PHASE_LONG, 1'b0);
        chk("b2b_count", int'(count), 30);
        chk("b2b_busy", int'(busy), 1);

        // Async reset mid-run at count 12
        do_ticks(18, 1, 0, 0, d);
        chk("rst_pre_count", int'(count), 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_ticks(4, 1, 0, 0, d);
        chk("rst_after_dones", d, 0);
        chk("rst_after_count", int'(count), 0);

`ifdef PRESET_TIMER_BCD_EN
        bvals[0] = PHASE_LONG; bvals[1] = PHASE_ALT; bvals[2] = PHASE_MID; bvals[3] = PHASE_SHORT;
        for (int i = 0; i < 4; i++) begin
            do_load(bvals[i], 1'b0);
            chk($sformatf("bcd_tens_%0d", bvals[i]), int'(bcd_tens), int'(bvals[i]) / 10);
            chk($sformatf("bcd_ones_%0d", bvals[i]), int'(bcd_ones), int'(bvals[i]) % 10);
        end
        do_load(6'd63, 1'b0);
        chk("bcd_tens_63", int'(bcd_tens), 6);
        chk("bcd_ones_63", int'(bcd_ones), 3);
`else
        bvals[0] = 6'd0; bvals[1] = 6'd0; bvals[2] = 6'd0; bvals[3] = 6'd0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
